// File: rtl/vga_pkg.sv
// Shared CSR map, bus widths and FSM state type for the VGA frame sequencer.
// Consumed by vga_frame_sequencer via import vga_pkg::*.
package vga_pkg;

  localparam int MM_CSR_ADDR_WIDTH = 4;
  localparam int MM_CSR_DATA_WIDTH = 32;

  localparam logic [MM_CSR_ADDR_WIDTH-1:0] VGA_STREAM_RESTART_REG = 4'd3;

  localparam logic [MM_CSR_ADDR_WIDTH-1:0] SEQ_CTRL_REG   = 4'd0;
  localparam logic [MM_CSR_ADDR_WIDTH-1:0] SEQ_STATUS_REG = 4'd1;
  localparam logic [MM_CSR_ADDR_WIDTH-1:0] SEQ_MISSED_REG = 4'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } vga_seq_state_t;

endpackage

// File: rtl/vga_frame_sequencer.sv
// Issues a stream-restart CSR write to the frame buffer mux per frame.
// Optional missed-vsync counter enabled by defining VGA_SEQ_MISSED_CNT_EN.
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter logic [MM_CSR_ADDR_WIDTH-1:0] MUX_CSR_ADDRESS = VGA_STREAM_RESTART_REG,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vsync_start,
  input  logic                         cpu_write,
  input  logic                         cpu_read,
  input  logic [MM_CSR_ADDR_WIDTH-1:0] cpu_address,
  input  logic [MM_CSR_DATA_WIDTH-1:0] cpu_writedata,
  output logic [MM_CSR_DATA_WIDTH-1:0] cpu_readdata,
  output logic                         mux_write,
  output logic [MM_CSR_ADDR_WIDTH-1:0] mux_address,
  output logic [MM_CSR_DATA_WIDTH-1:0] mux_writedata,
  input  logic                         mux_waitrequest
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  vga_seq_state_t state, state_nxt;

  logic        auto_en;
  logic        pending_req;
  logic        err;
  logic [15:0] frame_cnt;
  logic [15:0] tmo_cnt;

  logic go;
  logic tmo_hit;
  logic busy;
  logic sel_ctrl, sel_status, sel_missed;
  logic wr_ctrl, wr_status;
  logic oneshot;
  logic [MM_CSR_DATA_WIDTH-1:0] rd_mux;
  logic unused_wdata;

  assign sel_ctrl   = cpu_address == SEQ_CTRL_REG;
  assign sel_status = cpu_address == SEQ_STATUS_REG;
  assign sel_missed = cpu_address == SEQ_MISSED_REG;

  assign wr_ctrl   = cpu_write && sel_ctrl;
  assign wr_status = cpu_write && sel_status;
  assign oneshot   = wr_ctrl && cpu_writedata[1];

  assign go = (state == IDLE) &&
              ((auto_en && vsync_start) || pending_req);

  assign tmo_hit = tmo_cnt == TMO_LAST;
  assign busy    = (state != IDLE) || pending_req;

  assign unused_wdata = ^{cpu_writedata[31], cpu_writedata[29:2]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (go) state_nxt = WRITE;
      WRITE: begin
        if (!mux_waitrequest) state_nxt = DONE;
        else if (tmo_hit)     state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mux_write     = state == WRITE;
    mux_address   = MUX_CSR_ADDRESS;
    mux_writedata = MM_CSR_DATA_WIDTH'(1);
  end

  // Counter is held at zero outside WRITE, so it is clear on entry
  always_ff @(posedge clk) begin
    if (reset)               tmo_cnt <= '0;
    else if (state == WRITE) tmo_cnt <= tmo_cnt + 16'd1;
    else                     tmo_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)        auto_en <= 1'b0;
    else if (wr_ctrl) auto_en <= cpu_writedata[0];
  end

  // A oneshot coinciding with a launch merges into it
  always_ff @(posedge clk) begin
    if (reset)        pending_req <= 1'b0;
    else if (go)      pending_req <= 1'b0;
    else if (oneshot) pending_req <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                   err <= 1'b0;
    else if (state == ABORT)     err <= 1'b1;
    else if (wr_status &&
             cpu_writedata[30])  err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)              frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
  end

`ifdef VGA_SEQ_MISSED_CNT_EN
  logic [15:0] missed_cnt;
  logic        miss_evt;
  logic        wr_missed;

  assign wr_missed = cpu_write && sel_missed;
  assign miss_evt  = vsync_start && auto_en &&
                     ((state != IDLE) || pending_req);

  always_ff @(posedge clk) begin
    if (reset)          missed_cnt <= '0;
    else if (wr_missed) missed_cnt <= '0;
    else if (miss_evt &&
             missed_cnt != 16'hFFFF)
      missed_cnt <= missed_cnt + 16'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl:   rd_mux[0] = auto_en;
      sel_status: rd_mux = {busy, err, 14'd0, frame_cnt};
`ifdef VGA_SEQ_MISSED_CNT_EN
      sel_missed: rd_mux[15:0] = missed_cnt;
`else
      sel_missed: rd_mux = '0;
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         cpu_readdata <= '0;
    else if (cpu_read) cpu_readdata <= rd_mux;
  end

endmodule
